// File: rtl/serial_sub_if.sv
// serial_sub_if: start/busy/done handshake and operand/result bundle for serial_sub
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b - bin, LSB first, through a registered full-subtractor cell
module serial_sub #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, diff_q, diff_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d, br_n;
    assign d       = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_n    = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    assign bus.busy = state_q == SHIFT;
    assign bus.done = state_q == DONE;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    // state and datapath registers; reset also discards any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end
    // next state: load on start, one subtractor step per SHIFT cycle, publish on the last bit
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = SHIFT;
                sa_d    = bus.a;
                sb_d    = bus.b;
                br_d    = bus.bin;
                cnt_d   = '0;
                res_d   = '0;
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = {d, res_q[WIDTH-1:1]};
                br_d  = br_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = {d, res_q[WIDTH-1:1]};
                    bout_d  = br_n;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed checks of serial_sub at WIDTH=8 and WIDTH=2 against a timeline/arithmetic model
module tb_serial_sub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(8)) bus8 ();
    serial_sub_if #(.WIDTH(2)) bus2 ();
    serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_sub #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // model: phase 0 idle, 1..W busy, W+1 done; result is a-b-bin modulo 2^(W+1)
    int         ph8 = 0, ph2 = 0;
    logic [8:0] exp8 = '0, held8 = '0;
    logic [2:0] exp2 = '0, held2 = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            ph8 <= 0; held8 <= '0; ph2 <= 0; held2 <= '0;
        end else begin
            if (ph8 == 0) begin
                if (bus8.start) begin
                    ph8  <= 1;
                    exp8 <= {1'b0, bus8.a} - {1'b0, bus8.b} - 9'(bus8.bin);
                end
            end else if (ph8 == 9) ph8 <= 0;
            else begin
                ph8 <= ph8 + 1;
                if (ph8 == 8) held8 <= exp8;
            end
            if (ph2 == 0) begin
                if (bus2.start) begin
                    ph2  <= 1;
                    exp2 <= {1'b0, bus2.a} - {1'b0, bus2.b} - 3'(bus2.bin);
                end
            end else if (ph2 == 3) ph2 <= 0;
            else begin
                ph2 <= ph2 + 1;
                if (ph2 == 2) held2 <= exp2;
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("busy8", 32'(bus8.busy), 32'(ph8 >= 1 && ph8 <= 8));
            chk("done8", 32'(bus8.done), 32'(ph8 == 9));
            chk("res8", 32'({bus8.bout, bus8.diff}), 32'(held8));
            chk("busy2", 32'(bus2.busy), 32'(ph2 >= 1 && ph2 <= 2));
            chk("done2", 32'(bus2.done), 32'(ph2 == 3));
            chk("res2", 32'({bus2.bout, bus2.diff}), 32'(held2));
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [8:0] exp, input int exp_busy);
        int nb, n;
        bit seen;
        bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        nb = 0; n = 1; seen = 0;
        for (int t = 0; t < 30 && !seen; t++) begin
            if (bus8.done) seen = 1;
            else begin
                if (bus8.busy) nb++;
                n++;
                @(negedge clk);
            end
        end
        chk("op8_timeout", 32'(seen), 32'd1);
        chk("op8_done_at", 32'(n), 32'd9);
        if (exp_busy > 0) chk("op8_busy_cycles", 32'(nb), 32'(exp_busy));
        chk("op8_result", 32'({bus8.bout, bus8.diff}), 32'(exp));
        @(negedge clk);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bin);
        bit seen;
        bus2.a = a; bus2.b = b; bus2.bin = bin; bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (bus2.done) seen = 1;
            else @(negedge clk);
        end
        chk("op2_timeout", 32'(seen), 32'd1);
        chk("op2_result", 32'({bus2.bout, bus2.diff}), 32'(({1'b0, a} - {1'b0, b} - 3'(bin)) & 3'h7));
        @(negedge clk);
    endtask

    int         dcyc[$];
    logic [8:0] dval[$];

    initial begin
        bus8.start = 0; bus8.a = 0; bus8.b = 0; bus8.bin = 0;
        bus2.start = 0; bus2.a = 0; bus2.b = 0; bus2.bin = 0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus8.busy), 32'd0);
        chk("reset_done", 32'(bus8.done), 32'd0);
        chk("reset_res", 32'({bus8.bout, bus8.diff}), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        op8(8'd5, 8'd3, 1'b0, 9'h002, 8);
        repeat (20) @(negedge clk);
        chk("hold_after_20", 32'({bus8.bout, bus8.diff}), 32'h002);
        op8(8'd3, 8'd5, 1'b0, 9'h1FE, 8);
        op8(8'h00, 8'h00, 1'b1, 9'h1FF, 0);
        op8(8'hFF, 8'hFF, 1'b0, 9'h000, 0);
        op8(8'h80, 8'h01, 1'b1, 9'h07E, 0);
        bus8.a = 8'h20; bus8.b = 8'h07; bus8.bin = 1'b0; bus8.start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                dcyc.push_back(cyc);
                dval.push_back({bus8.bout, bus8.diff});
            end
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
        end
        bus8.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("cont_done_count", 32'(dcyc.size() >= 3), 32'd1);
        if (dval.size() > 0) chk("cont_first_result", 32'(dval[0]), 32'h019);
        for (int i = 1; i < dcyc.size(); i++) chk("cont_spacing", 32'(dcyc[i] - dcyc[i-1]), 32'd10);
        bus8.a = 8'h55; bus8.b = 8'h11; bus8.bin = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_shift_busy", 32'(bus8.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(bus8.busy), 32'd0);
        chk("rst_mid_done", 32'(bus8.done), 32'd0);
        chk("rst_mid_res", 32'({bus8.bout, bus8.diff}), 32'd0);
        op8(8'h10, 8'h01, 1'b0, 9'h00F, 8);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++) op2(2'(a), 2'(b), 1'(c));
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
